// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: frame states and line levels.
package uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read port of the asynchronous FIFO as seen from the read clock domain.
interface fifo_uart_tx_if;
    import uart_pkg::*;

    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_rd_en;

    modport master (output fifo_rd_en, input fifo_empty, input fifo_data);
    modport slave  (input fifo_rd_en, output fifo_empty, output fifo_data);

endinterface

// File: rtl/baud_tick.sv
// Bit-period counter: tick marks the last cycle of each bit, pre_tick the cycle before it.
module baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic r_clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic pre_tick
);

    localparam int             W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0]   LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0]   PRE  = W'(CLKS_PER_BIT - 2);

    logic [W-1:0] cnt;

    // NOTE: non-blocking assignments for registered state, so every flop sees pre-edge values.
    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick     = enable && (cnt == LAST);
    assign pre_tick = enable && (cnt == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and serializes them as UART frames; all outputs registered.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           r_clk,
    input  logic           rst,
    input  logic           tx_en,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           frame_done
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    state_t               state, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [2:0]           bit_idx, bit_next;
    logic                 stop_cnt, stop_next;
    logic                 parity, parity_next;
    logic                 tx_next, rd_next, busy_next, done_next;
    logic                 in_frame, tick, pre_tick;

    assign in_frame = state inside {START, DATA, PARITY, STOP};

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .r_clk    (r_clk),
        .rst      (rst),
        .clear    (!in_frame),
        .enable   (in_frame),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            shift_reg       <= '0;
            bit_idx         <= '0;
            stop_cnt        <= 1'b0;
            parity          <= 1'b0;
            tx              <= IDLE_LEVEL;
            fifo.fifo_rd_en <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            state           <= state_next;
            shift_reg       <= shift_next;
            bit_idx         <= bit_next;
            stop_cnt        <= stop_next;
            parity          <= parity_next;
            tx              <= tx_next;
            fifo.fifo_rd_en <= rd_next;
            busy            <= busy_next;
            frame_done      <= done_next;
        end
    end

    // Outputs are computed for the state being entered, so each register holds its level for that state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_next  = state;
        shift_next  = shift_reg;
        bit_next    = bit_idx;
        stop_next   = stop_cnt;
        parity_next = parity;
        tx_next     = tx;

        case (state)
            IDLE: begin
                tx_next = IDLE_LEVEL;
                if (tx_en && !fifo.fifo_empty) state_next = REQ;
            end
            REQ: state_next = LOAD;
            LOAD: begin
                shift_next  = fifo.fifo_data;
                parity_next = ^fifo.fifo_data;
                bit_next    = '0;
                stop_next   = 1'b0;
                tx_next     = START_LEVEL;
                state_next  = START;
            end
            START: if (tick) begin
                tx_next    = shift_reg[0];
                state_next = DATA;
            end
            DATA: if (tick) begin
                shift_next = shift_reg >> 1;
                if (bit_idx == LAST_BIT) begin
                    if (PARITY_EN != 0) begin
                        tx_next    = parity;
                        state_next = PARITY;
                    end else begin
                        tx_next    = IDLE_LEVEL;
                        state_next = STOP;
                    end
                end else begin
                    bit_next = bit_idx + 1'b1;
                    tx_next  = shift_reg[1];
                end
            end
            PARITY: if (tick) begin
                tx_next    = IDLE_LEVEL;
                state_next = STOP;
            end
            STOP: if (tick) begin
                if (stop_cnt == STOP_LAST) state_next = IDLE;
                else                       stop_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        rd_next   = (state_next == REQ);
        busy_next = (state_next != IDLE);
        done_next = (state == STOP) && (stop_cnt == STOP_LAST) && pre_tick;
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three configurations fed by FIFO models, frames checked against spec-built bit patterns.
module tb_fifo_uart_tx;

    localparam int CPB  = 4;
    localparam int NDUT = 3;

    function automatic int cfg_par(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic int cfg_stop(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en_v [NDUT];
    wire        tx_w    [NDUT];
    wire        busy_w  [NDUT];
    wire        done_w  [NDUT];
    wire        rd_w    [NDUT];
    wire [31:0] pops_w  [NDUT];
    logic [7:0] fmem    [NDUT][64];
    int         wr_ptr  [NDUT];
    int         n_assert = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        fifo_uart_tx_if fif ();
        int         rd_ptr = 0;
        logic [7:0] fdata  = '0;

        assign fif.fifo_empty = (rd_ptr == wr_ptr[g]);
        assign fif.fifo_data  = fdata;
        assign rd_w[g]        = fif.fifo_rd_en;
        assign pops_w[g]      = rd_ptr;

        // Read data appears the cycle after the pop strobe.
        always @(posedge clk) begin
            if (fif.fifo_rd_en && !fif.fifo_empty) begin
                fdata  <= fmem[g][rd_ptr % 64];
                rd_ptr <= rd_ptr + 1;
            end
        end

        fifo_uart_tx #(
            .CLKS_PER_BIT (CPB),
            .PARITY_EN    (cfg_par(g)),
            .STOP_BITS    (cfg_stop(g))
        ) u_dut (
            .r_clk      (clk),
            .rst        (rst),
            .tx_en      (tx_en_v[g]),
            .fifo       (fif),
            .tx         (tx_w[g]),
            .busy       (busy_w[g]),
            .frame_done (done_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        fmem[d][wr_ptr[d] % 64] = b;
        wr_ptr[d]++;
    endtask

    // Waits for the start bit, then checks every cycle of one frame against the bit pattern
    // start/data LSB-first/even parity/stop; 'waited' counts negedges up to the first start cycle.
    task automatic check_frame(input int d, input logic [7:0] b, input bit drop_en, output int waited);
        logic [11:0] fv;
        int          fl;
        bit          found;
        fv = '1;
        fv[0] = 1'b0;
        for (int i = 0; i < 8; i++) fv[1 + i] = b[i];
        if (cfg_par(d) != 0) fv[9] = ^b;
        fl = (9 + cfg_par(d) + cfg_stop(d)) * CPB;
        found  = 1'b0;
        waited = 0;
        while (!found && waited < 400) begin
            @(negedge clk);
            waited++;
            if (tx_w[d] === 1'b0) found = 1'b1;
        end
        check($sformatf("d%0d start_seen", d), 32'(found), 32'd1);
        if (!found) return;
        for (int c = 0; c < fl; c++) begin
            if (c > 0) @(negedge clk);
            if (drop_en && c == 1) tx_en_v[d] = 1'b0;
            check($sformatf("d%0d b%02h tx c%0d", d, b, c), 32'(tx_w[d]), 32'(fv[c / CPB]));
            check($sformatf("d%0d b%02h done c%0d", d, b, c), 32'(done_w[d]), (c == fl - 1) ? 32'd1 : 32'd0);
            check($sformatf("d%0d b%02h busy c%0d", d, b, c), 32'(busy_w[d]), 32'd1);
            check($sformatf("d%0d b%02h rd c%0d", d, b, c), 32'(rd_w[d]), 32'd0);
        end
    endtask

    initial begin
        int         w;
        int         n;
        bit         seen;
        bit         found;
        int         pops_exp;
        logic [7:0] bq [8];

        for (int d = 0; d < NDUT; d++) tx_en_v[d] = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst d%0d tx", d), 32'(tx_w[d]), 32'd1);
            check($sformatf("rst d%0d busy", d), 32'(busy_w[d]), 32'd0);
            check($sformatf("rst d%0d rd", d), 32'(rd_w[d]), 32'd0);
            check($sformatf("rst d%0d done", d), 32'(done_w[d]), 32'd0);
        end
        rst = 1'b0;

        repeat (5) @(negedge clk);
        check("empty_idle_busy", 32'(busy_w[0]), 32'd0);
        check("empty_idle_pops", pops_w[0], 32'd0);

        // Single byte from idle.
        push(0, 8'hA5);
        check_frame(0, 8'hA5, 1'b0, w);
        check("a5_latency", 32'(w), 32'd3);
        check("a5_pops", pops_w[0], 32'd1);
        @(negedge clk);
        check("a5_idle_tx", 32'(tx_w[0]), 32'd1);
        check("a5_idle_busy", 32'(busy_w[0]), 32'd0);
        check("a5_done_once", 32'(done_w[0]), 32'd0);

        // Back-to-back frames with a preloaded FIFO.
        @(negedge clk);
        push(0, 8'h00);
        push(0, 8'hFF);
        check_frame(0, 8'h00, 1'b0, w);
        check("b2b_latency", 32'(w), 32'd3);
        check_frame(0, 8'hFF, 1'b0, w);
        check("b2b_gap", 32'(w), 32'd4);
        check("b2b_pops", pops_w[0], 32'd3);

        // tx_en dropped during the start bit: frame completes, no further pop until re-enabled.
        @(negedge clk);
        push(0, 8'h55);
        push(0, 8'h11);
        check_frame(0, 8'h55, 1'b1, w);
        check("en_latency", 32'(w), 32'd3);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rd_w[0] !== 1'b0 || tx_w[0] !== 1'b1) seen = 1'b1;
        end
        check("en_low_quiet", 32'(seen), 32'd0);
        check("en_low_pops", pops_w[0], 32'd4);
        tx_en_v[0] = 1'b1;
        @(negedge clk);
        check("resume_pop", 32'(rd_w[0]), 32'd1);
        check_frame(0, 8'h11, 1'b0, w);
        check("resume_latency", 32'(w), 32'd2);

        // Reset in the middle of the data bits.
        @(negedge clk);
        push(0, 8'h00);
        push(0, 8'h5A);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (tx_w[0] === 1'b0) found = 1'b1;
        end
        check("rst_frame_started", 32'(found), 32'd1);
        repeat (CPB + 2) @(negedge clk);
        check("pre_rst_tx", 32'(tx_w[0]), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx_w[0]), 32'd1);
        check("mid_rst_busy", 32'(busy_w[0]), 32'd0);
        check("mid_rst_rd", 32'(rd_w[0]), 32'd0);
        @(negedge clk);
        check("held_rst_tx", 32'(tx_w[0]), 32'd1);
        check("held_rst_rd", 32'(rd_w[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_pop", 32'(rd_w[0]), 32'd1);
        check_frame(0, 8'h5A, 1'b0, w);
        check("post_rst_latency", 32'(w), 32'd2);
        check("post_rst_pops", pops_w[0], 32'd7);

        // Random bursts of random bytes.
        pops_exp = 7;
        for (int burst = 0; burst < 4; burst++) begin
            @(negedge clk);
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                bq[i] = 8'($urandom);
                push(0, bq[i]);
            end
            for (int i = 0; i < n; i++) begin
                check_frame(0, bq[i], 1'b0, w);
                check($sformatf("rand b%0d f%0d gap", burst, i), 32'(w), (i == 0) ? 32'd3 : 32'd4);
            end
            pops_exp += n;
            check($sformatf("rand b%0d pops", burst), pops_w[0], 32'(pops_exp));
        end

        // Even parity configuration.
        @(negedge clk);
        push(1, 8'h07);
        push(1, 8'h03);
        check_frame(1, 8'h07, 1'b0, w);
        check("par_latency", 32'(w), 32'd3);
        check_frame(1, 8'h03, 1'b0, w);
        check("par_gap", 32'(w), 32'd4);
        check("par_pops", pops_w[1], 32'd2);

        // Two stop bits.
        @(negedge clk);
        push(2, 8'h81);
        check_frame(2, 8'h81, 1'b0, w);
        check("stop2_latency", 32'(w), 32'd3);
        @(negedge clk);
        check("stop2_idle_done", 32'(done_w[2]), 32'd0);
        check("stop2_idle_busy", 32'(busy_w[2]), 32'd0);
        check("stop2_pops", pops_w[2], 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
